// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake and a programmable bit period.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_rdy,
  output logic       tx_out,
  output logic       tx_busy
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_out_q, tx_out_d;
  logic             tx_rdy_q, tx_rdy_d;
  logic             tx_busy_q, tx_busy_d;
  logic             bit_last;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_last = (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (state_q != IDLE && !bit_last) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (tx_valid && tx_rdy_q) begin
          state_d = START;
          shift_d = tx_data;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        if (bit_last) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_last) begin
          shift_d = shift_q >> 1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_last) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_out_d = parity_d;
`endif
      default: tx_out_d = 1'b1;
    endcase
    tx_busy_d = (state_d != IDLE);
    tx_rdy_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_out_q  <= 1'b1;
      tx_rdy_q  <= 1'b0;
      tx_busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_out_q  <= tx_out_d;
      tx_rdy_q  <= tx_rdy_d;
      tx_busy_q <= tx_busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_out  = tx_out_q;
  assign tx_rdy  = tx_rdy_q;
  assign tx_busy = tx_busy_q;

endmodule
